// File: rtl/mem_access_if.sv
// Request, data-bus and writeback signals of the MEM-stage load/store unit.
// slave: the unit itself; master: the surrounding pipeline and memory.
interface mem_access_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        adel;
  logic        ades;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, flush,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  out_ready,
    output in_ready,
    output data_req, data_wr, data_size, data_addr,
    output data_wstrb, data_wdata,
    output out_valid, out_data, adel, ades
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, flush,
    output data_addr_ok, data_data_ok, data_rdata,
    output out_ready,
    input  in_ready,
    input  data_req, data_wr, data_size, data_addr,
    input  data_wstrb, data_wdata,
    input  out_valid, out_data, adel, ades
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store unit: alignment check, one SRAM-like bus access,
// load data alignment/extension. Ports: clk, reset (async high), bus.
module mem_access #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DISCARD, RESP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [7:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic        adel_q;
  logic        ades_q;

  logic        accept;
  logic        half_in;
  logic        word_in;
  logic        load_in;
  logic        mis_in;
  logic        capture;
  logic        is_store;

  function automatic logic [31:0] load_ext(
    input logic [7:0]  op,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    unique case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    unique case (1'b1)
      op[0]:   load_ext = {{24{b[7]}}, b};
      op[1]:   load_ext = {24'd0, b};
      op[2]:   load_ext = {{16{h[15]}}, h};
      op[3]:   load_ext = {16'd0, h};
      op[4]:   load_ext = d;
      default: load_ext = 32'd0;
    endcase
  endfunction

  assign accept  = bus.in_valid && (state == IDLE);
  assign half_in = bus.in_op[2] | bus.in_op[3] | bus.in_op[6];
  assign word_in = bus.in_op[4] | bus.in_op[7];
  assign load_in = |bus.in_op[4:0];
  assign mis_in  = ALIGN_CHECK &&
                   ((half_in && bus.in_addr[0]) ||
                    (word_in && |bus.in_addr[1:0]));
  assign is_store = |op_q[7:5];

  // Load data is taken only for a live (unflushed) access.
  assign capture = !bus.flush && bus.data_data_ok &&
                   ((state == REQ && bus.data_addr_ok) ||
                    state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = mis_in ? RESP : REQ;
      end
      REQ: begin
        if (bus.flush) begin
          // A flushed access that is already accepted must
          // still drain its response unless it completes now.
          if (bus.data_addr_ok && !bus.data_data_ok)
            state_nx = DISCARD;
          else
            state_nx = IDLE;
        end else if (bus.data_addr_ok) begin
          state_nx = bus.data_data_ok ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (bus.flush)
          state_nx = bus.data_data_ok ? IDLE : DISCARD;
        else if (bus.data_data_ok)
          state_nx = RESP;
      end
      DISCARD: begin
        if (bus.data_data_ok) state_nx = IDLE;
      end
      RESP: begin
        if (bus.flush || bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.in_op;
      addr_q  <= bus.in_addr;
      wdata_q <= bus.in_wdata;
      data_q  <= '0;
      adel_q  <= mis_in && load_in;
      ades_q  <= mis_in && !load_in;
    end else if (capture) begin
      data_q  <= load_ext(op_q, addr_q[1:0], bus.data_rdata);
    end
  end

  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.out_valid  = (state == RESP);
    bus.out_data   = data_q;
    bus.adel       = (state == RESP) && adel_q;
    bus.ades       = (state == RESP) && ades_q;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'd0;
    bus.data_addr  = '0;
    bus.data_wstrb = 4'd0;
    bus.data_wdata = '0;
    if (state == REQ) begin
      bus.data_req  = 1'b1;
      bus.data_wr   = is_store;
      bus.data_addr = addr_q;
      unique case (1'b1)
        op_q[0], op_q[1]: bus.data_size = 2'd0;
        op_q[2], op_q[3]: bus.data_size = 2'd1;
        op_q[4]:          bus.data_size = 2'd2;
        op_q[5]: begin
          bus.data_size  = 2'd0;
          bus.data_wstrb = 4'b0001 << addr_q[1:0];
          bus.data_wdata = {4{wdata_q[7:0]}};
        end
        op_q[6]: begin
          bus.data_size  = 2'd1;
          bus.data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
          bus.data_wdata = {2{wdata_q[15:0]}};
        end
        op_q[7]: begin
          bus.data_size  = 2'd2;
          bus.data_wstrb = 4'hF;
          bus.data_wdata = wdata_q;
        end
        default: bus.data_size = 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table plus
// hand-written multi-cycle sequences.
module tb_mem_access;

  localparam logic [7:0] LB  = 8'h01;
  localparam logic [7:0] LBU = 8'h02;
  localparam logic [7:0] LH  = 8'h04;
  localparam logic [7:0] LHU = 8'h08;
  localparam logic [7:0] LW  = 8'h10;
  localparam logic [7:0] SB  = 8'h20;
  localparam logic [7:0] SH  = 8'h40;
  localparam logic [7:0] SW  = 8'h80;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_adel;
    logic        exp_ades;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[13];

  mem_access_if ifc ();

  mem_access #(.ALIGN_CHECK(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    ifc.in_op    = op;
    ifc.in_addr  = a;
    ifc.in_wdata = wd;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  task automatic release_resp();
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
  endtask

  task automatic bus_cycle(input logic aok, input logic dok,
                           input logic [31:0] rd);
    ifc.data_addr_ok = aok;
    ifc.data_data_ok = dok;
    ifc.data_rdata   = rd;
    @(posedge clk);
    #1;
    ifc.data_addr_ok = 1'b0;
    ifc.data_data_ok = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    issue(v.op, v.addr, v.wdata);
    @(negedge clk);
    if (v.exp_adel || v.exp_ades) begin
      chk($sformatf("v%0d_req", i), 32'(ifc.data_req), 32'd0);
      chk($sformatf("v%0d_ovalid", i), 32'(ifc.out_valid), 32'd1);
    end else begin
      chk($sformatf("v%0d_req", i), 32'(ifc.data_req), 32'd1);
      chk($sformatf("v%0d_wr", i), 32'(ifc.data_wr), 32'(v.exp_wr));
      chk($sformatf("v%0d_size", i), 32'(ifc.data_size),
          32'(v.exp_size));
      chk($sformatf("v%0d_addr", i), ifc.data_addr, v.addr);
      chk($sformatf("v%0d_wstrb", i), 32'(ifc.data_wstrb),
          32'(v.exp_wstrb));
      if (v.exp_wr)
        chk($sformatf("v%0d_wdata", i), ifc.data_wdata, v.exp_wdata);
      bus_cycle(1'b1, 1'b1, v.rdata);
      @(negedge clk);
      chk($sformatf("v%0d_ovalid", i), 32'(ifc.out_valid), 32'd1);
    end
    chk($sformatf("v%0d_data", i), ifc.out_data, v.exp_data);
    chk($sformatf("v%0d_adel", i), 32'(ifc.adel), 32'(v.exp_adel));
    chk($sformatf("v%0d_ades", i), 32'(ifc.ades), 32'(v.exp_ades));
    release_resp();
    @(negedge clk);
    chk($sformatf("v%0d_rdy", i), 32'(ifc.in_ready), 32'd1);
    chk($sformatf("v%0d_ovdone", i), 32'(ifc.out_valid), 32'd0);
  endtask

  initial begin
    ifc.in_valid     = 1'b0;
    ifc.in_op        = '0;
    ifc.in_addr      = '0;
    ifc.in_wdata     = '0;
    ifc.flush        = 1'b0;
    ifc.data_addr_ok = 1'b0;
    ifc.data_data_ok = 1'b0;
    ifc.data_rdata   = '0;
    ifc.out_ready    = 1'b0;

    //          op   addr          wdata         rdata
    //          data          adel ades wr size wstrb wdata
    vecs[0]  = '{LW,  32'h1000, 32'h0, 32'hDEADBEEF,
                 32'hDEADBEEF, 0, 0, 0, 2, 4'h0, 32'h0};
    vecs[1]  = '{LB,  32'h1003, 32'h0, 32'h80123456,
                 32'hFFFFFF80, 0, 0, 0, 0, 4'h0, 32'h0};
    vecs[2]  = '{LBU, 32'h1003, 32'h0, 32'h80123456,
                 32'h00000080, 0, 0, 0, 0, 4'h0, 32'h0};
    vecs[3]  = '{LH,  32'h1002, 32'h0, 32'h80123456,
                 32'hFFFF8012, 0, 0, 0, 1, 4'h0, 32'h0};
    vecs[4]  = '{LHU, 32'h1000, 32'h0, 32'h8012C456,
                 32'h0000C456, 0, 0, 0, 1, 4'h0, 32'h0};
    vecs[5]  = '{LB,  32'h1001, 32'h0, 32'h80123456,
                 32'h00000034, 0, 0, 0, 0, 4'h0, 32'h0};
    vecs[6]  = '{SB,  32'h2001, 32'h000000A5, 32'hFFFFFFFF,
                 32'h0, 0, 0, 1, 0, 4'b0010, 32'hA5A5A5A5};
    vecs[7]  = '{SW,  32'h2004, 32'h12345678, 32'hFFFFFFFF,
                 32'h0, 0, 0, 1, 2, 4'hF, 32'h12345678};
    vecs[8]  = '{SH,  32'h2000, 32'h1234ABCD, 32'hFFFFFFFF,
                 32'h0, 0, 0, 1, 1, 4'b0011, 32'hABCDABCD};
    vecs[9]  = '{LW,  32'h3001, 32'h0, 32'h0,
                 32'h0, 1, 0, 0, 0, 4'h0, 32'h0};
    vecs[10] = '{SW,  32'h3002, 32'h0, 32'h0,
                 32'h0, 0, 1, 0, 0, 4'h0, 32'h0};
    vecs[11] = '{LH,  32'h3001, 32'h0, 32'h0,
                 32'h0, 1, 0, 0, 0, 4'h0, 32'h0};
    vecs[12] = '{SH,  32'h3003, 32'h0, 32'h0,
                 32'h0, 0, 1, 0, 0, 4'h0, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_req", 32'(ifc.data_req), 32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_data", ifc.out_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    // SH with addr_ok held off for 3 cycles, then split data_ok.
    issue(SH, 32'h2002, 32'h1234ABCD);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("sh_req%0d", k), 32'(ifc.data_req), 32'd1);
      chk($sformatf("sh_wr%0d", k), 32'(ifc.data_wr), 32'd1);
      chk($sformatf("sh_size%0d", k), 32'(ifc.data_size), 32'd1);
      chk($sformatf("sh_addr%0d", k), ifc.data_addr, 32'h2002);
      chk($sformatf("sh_wstrb%0d", k), 32'(ifc.data_wstrb),
          32'b1100);
      chk($sformatf("sh_wdata%0d", k), ifc.data_wdata, 32'hABCDABCD);
    end
    bus_cycle(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("sh_wait_req", 32'(ifc.data_req), 32'd0);
    chk("sh_wait_ov", 32'(ifc.out_valid), 32'd0);
    bus_cycle(1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk("sh_resp_ov", 32'(ifc.out_valid), 32'd1);
    chk("sh_resp_data", ifc.out_data, 32'd0);
    release_resp();

    // Flush in the addr_ok cycle, response 4 cycles later.
    issue(LW, 32'h4000, 32'h0);
    @(negedge clk);
    chk("fl_req", 32'(ifc.data_req), 32'd1);
    ifc.flush = 1'b1;
    bus_cycle(1'b1, 1'b0, 32'h0);
    ifc.flush    = 1'b0;
    ifc.in_op    = LW;
    ifc.in_addr  = 32'h4004;
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("fl_rdy%0d", k), 32'(ifc.in_ready), 32'd0);
      chk($sformatf("fl_ov%0d", k), 32'(ifc.out_valid), 32'd0);
      chk($sformatf("fl_req%0d", k), 32'(ifc.data_req), 32'd0);
    end
    bus_cycle(1'b0, 1'b1, 32'h55555555);
    @(negedge clk);
    chk("fl_rdy_after", 32'(ifc.in_ready), 32'd1);
    chk("fl_ov_after", 32'(ifc.out_valid), 32'd0);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_next_req", 32'(ifc.data_req), 32'd1);
    chk("fl_next_addr", ifc.data_addr, 32'h4004);
    bus_cycle(1'b1, 1'b1, 32'h11223344);
    @(negedge clk);
    chk("fl_next_data", ifc.out_data, 32'h11223344);
    release_resp();

    // out_ready held low for 5 cycles in RESP.
    issue(LW, 32'h5000, 32'h0);
    @(negedge clk);
    bus_cycle(1'b1, 1'b1, 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_ov%0d", k), 32'(ifc.out_valid), 32'd1);
      chk($sformatf("hold_d%0d", k), ifc.out_data, 32'hCAFEF00D);
      chk($sformatf("hold_rdy%0d", k), 32'(ifc.in_ready), 32'd0);
    end
    release_resp();

    // Flush in RESP drops the result.
    issue(LW, 32'h5004, 32'h0);
    @(negedge clk);
    bus_cycle(1'b1, 1'b1, 32'h0BADF00D);
    @(negedge clk);
    chk("rfl_ov", 32'(ifc.out_valid), 32'd1);
    ifc.flush = 1'b1;
    @(posedge clk);
    #1 ifc.flush = 1'b0;
    @(negedge clk);
    chk("rfl_ov_after", 32'(ifc.out_valid), 32'd0);
    chk("rfl_rdy_after", 32'(ifc.in_ready), 32'd1);

    // Flush in REQ without addr_ok returns straight to IDLE.
    issue(LW, 32'h7000, 32'h0);
    @(negedge clk);
    ifc.flush = 1'b1;
    @(posedge clk);
    #1 ifc.flush = 1'b0;
    @(negedge clk);
    chk("rqfl_rdy", 32'(ifc.in_ready), 32'd1);
    chk("rqfl_req", 32'(ifc.data_req), 32'd0);

    // Asynchronous reset while waiting for data_ok.
    issue(LW, 32'h6000, 32'h0);
    @(negedge clk);
    bus_cycle(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("wr_wait_rdy", 32'(ifc.in_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("ar_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("ar_req", 32'(ifc.data_req), 32'd0);
    chk("ar_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("ar_out_data", ifc.out_data, 32'd0);
    chk("ar_adel", 32'(ifc.adel), 32'd0);
    chk("ar_ades", 32'(ifc.ades), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
